// File: rtl/beat_sequencer_if.sv
// Decoder/console side of the beat sequencer: requests in, beat vector and status out.
// BEAT_CNT/INSTR_CNT carry data only when BEAT_SEQ_PERF_CNT_EN is defined.
interface beat_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             QD;
  logic             STEP_MODE;
  logic             SHORT;
  logic             LONG;
  logic             STOP;
  logic [3:1]       W;
  logic             RUN;
  logic             INSTR_END;
  logic [CNT_W-1:0] BEAT_CNT;
  logic [CNT_W-1:0] INSTR_CNT;

  modport master (
    output QD, STEP_MODE, SHORT, LONG, STOP,
    input  W, RUN, INSTR_END, BEAT_CNT, INSTR_CNT
  );

  modport slave (
    input  QD, STEP_MODE, SHORT, LONG, STOP,
    output W, RUN, INSTR_END, BEAT_CNT, INSTR_CNT
  );
endinterface

// File: rtl/beat_sequencer.sv
// One-hot beat generator W[3:1] with run/pause/single-step control driven by QD.
// Optional performance counters are enabled by defining BEAT_SEQ_PERF_CNT_EN.
module beat_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic            T3,
  input logic            CLR,
  beat_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    B1    = 3'd1,
    B2    = 3'd2,
    B3    = 3'd3,
    PAUSE = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 r_resume;
  logic [3:1]             r_w;
  logic                   r_run;
  logic [SYNC_STAGES-1:0] r_qd_sync;
  logic                   r_qd_dly;

  state_t                 w_next;
  state_t                 w_resume_next;
  state_t                 w_follow;
  logic                   w_qd_edge;
  logic                   w_last;
  logic [3:1]             w_w_next;

  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      r_qd_sync <= '0;
      r_qd_dly  <= 1'b0;
    end else begin
      r_qd_sync <= {r_qd_sync[SYNC_STAGES-2:0], bus.QD};
      r_qd_dly  <= r_qd_sync[SYNC_STAGES-1];
    end
  end

  assign w_qd_edge = r_qd_sync[SYNC_STAGES-1] & ~r_qd_dly;

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      B1:      w_last = bus.SHORT;
      B2:      w_last = ~bus.LONG;
      B3:      w_last = 1'b1;
      default: w_last = 1'b0;
    endcase
  end

  assign bus.INSTR_END = w_last;

  // STOP outranks step mode; both park in PAUSE with the beat to resume at.
  always_comb begin
    w_next        = r_state;
    w_resume_next = r_resume;
    w_follow      = B1;
    if (!w_last)
      w_follow = (r_state == B1) ? B2 : B3;
    case (r_state)
      IDLE:  if (w_qd_edge) w_next = B1;
      B1, B2, B3: begin
        if (bus.STOP) begin
          w_next        = PAUSE;
          w_resume_next = w_follow;
        end else if (w_last && bus.STEP_MODE) begin
          w_next        = PAUSE;
          w_resume_next = B1;
        end else begin
          w_next = w_follow;
        end
      end
      PAUSE: if (w_qd_edge) w_next = r_resume;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_w_next = '0;
    case (w_next)
      B1:      w_w_next = 3'b001;
      B2:      w_w_next = 3'b010;
      B3:      w_w_next = 3'b100;
      default: w_w_next = '0;
    endcase
  end

  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      r_state  <= IDLE;
      r_resume <= B1;
      r_w      <= '0;
      r_run    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_resume <= w_resume_next;
      r_w      <= w_w_next;
      r_run    <= |w_w_next;
    end
  end

  assign bus.W   = r_w;
  assign bus.RUN = r_run;

`ifdef BEAT_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  always_ff @(posedge T3 or posedge CLR) begin
    if (CLR) begin
      r_beat_cnt  <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_run)  r_beat_cnt  <= r_beat_cnt + CNT_W'(1);
      if (w_last) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign bus.BEAT_CNT  = r_beat_cnt;
  assign bus.INSTR_CNT = r_instr_cnt;
`else
  assign bus.BEAT_CNT  = {CNT_W{1'b0}};
  assign bus.INSTR_CNT = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: start, 1/2/3-beat instructions, stop/resume, step mode, async clear and counters.
module tb_beat_sequencer;

  localparam int unsigned CW = 4;
`ifdef BEAT_SEQ_PERF_CNT_EN
  localparam logic [CW-1:0] EXP_WRAP = 4'd1;
`else
  localparam logic [CW-1:0] EXP_WRAP = 4'd0;
`endif

  logic T3;
  logic CLR;
  int   checks;
  int   errors;

  beat_sequencer_if #(.CNT_W(CW)) bus ();

  beat_sequencer #(.SYNC_STAGES(2), .CNT_W(CW)) dut (
    .T3  (T3),
    .CLR (CLR),
    .bus (bus)
  );

  initial T3 = 1'b0;
  always #5 T3 = ~T3;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge T3);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    bus.QD = 1'b0; bus.STEP_MODE = 1'b0; bus.SHORT = 1'b0; bus.LONG = 1'b0; bus.STOP = 1'b0;
    step(); step();
    checks++; if (bus.W !== 3'b000) begin errors++; $display("FAIL reset_w actual=%b required=000", bus.W); end
    checks++; if (bus.RUN !== 1'b0) begin errors++; $display("FAIL reset_run actual=%b required=0", bus.RUN); end
    checks++; if (bus.INSTR_END !== 1'b0) begin errors++; $display("FAIL reset_iend actual=%b required=0", bus.INSTR_END); end
    checks++; if (bus.BEAT_CNT !== 4'd0 || bus.INSTR_CNT !== 4'd0) begin
      errors++; $display("FAIL reset_cnt actual=%0d/%0d required=0/0", bus.BEAT_CNT, bus.INSTR_CNT); end
    CLR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.W !== 3'b000) begin errors++; $display("FAIL idle_hold actual=%b required=000", bus.W); end
    end
  endtask

  task automatic test_start_short();
    bus.SHORT = 1'b1;
    bus.QD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.W !== 3'b000) begin errors++; $display("FAIL start_latency cyc=%0d actual=%b required=000", i, bus.W); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.W !== 3'b001 || bus.RUN !== 1'b1 || bus.INSTR_END !== 1'b1) begin
        errors++; $display("FAIL short_beat cyc=%0d actual=%b/%b/%b required=001/1/1", i, bus.W, bus.RUN, bus.INSTR_END); end
    end
  endtask

  task automatic test_two_beat();
    logic [3:1] exp_w [4];
    exp_w[0] = 3'b010; exp_w[1] = 3'b001; exp_w[2] = 3'b010; exp_w[3] = 3'b001;
    bus.SHORT = 1'b0; bus.LONG = 1'b0;
    #1;
    checks++; if (bus.INSTR_END !== 1'b0) begin errors++; $display("FAIL two_iend_b1 actual=%b required=0", bus.INSTR_END); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.W !== exp_w[i] || bus.INSTR_END !== (exp_w[i] == 3'b010)) begin
        errors++; $display("FAIL two_beat cyc=%0d actual=%b/%b required=%b/%b", i, bus.W, bus.INSTR_END, exp_w[i], exp_w[i] == 3'b010); end
    end
  endtask

  task automatic test_three_beat();
    logic [3:1] exp_w [6];
    exp_w[0] = 3'b010; exp_w[1] = 3'b100; exp_w[2] = 3'b001;
    exp_w[3] = 3'b010; exp_w[4] = 3'b100; exp_w[5] = 3'b001;
    bus.LONG = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.W !== exp_w[i] || bus.INSTR_END !== (exp_w[i] == 3'b100)) begin
        errors++; $display("FAIL three_beat cyc=%0d actual=%b/%b required=%b/%b", i, bus.W, bus.INSTR_END, exp_w[i], exp_w[i] == 3'b100); end
    end
    bus.SHORT = 1'b1;
    #1;
    checks++; if (bus.INSTR_END !== 1'b1) begin errors++; $display("FAIL short_wins_iend actual=%b required=1", bus.INSTR_END); end
    step();
    checks++; if (bus.W !== 3'b001) begin errors++; $display("FAIL short_wins_w actual=%b required=001", bus.W); end
    bus.SHORT = 1'b0; bus.LONG = 1'b0;
  endtask

  task automatic test_stop_resume();
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0; bus.QD = 1'b0;
    checks++; if (bus.W !== 3'b000 || bus.RUN !== 1'b0) begin
      errors++; $display("FAIL stop_pause actual=%b/%b required=000/0", bus.W, bus.RUN); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.W !== 3'b000) begin errors++; $display("FAIL pause_hold cyc=%0d actual=%b required=000", i, bus.W); end
    end
    bus.QD = 1'b1;
    step(); step();
    checks++; if (bus.W !== 3'b000) begin errors++; $display("FAIL resume_latency actual=%b required=000", bus.W); end
    step();
    checks++; if (bus.W !== 3'b010) begin errors++; $display("FAIL resume_beat actual=%b required=010", bus.W); end
    step();
    checks++; if (bus.W !== 3'b001) begin errors++; $display("FAIL resume_next actual=%b required=001", bus.W); end
  endtask

  task automatic test_step_mode();
    int beats;
    bus.STEP_MODE = 1'b1;
    step();
    checks++; if (bus.W !== 3'b010) begin errors++; $display("FAIL step_b2 actual=%b required=010", bus.W); end
    step();
    checks++; if (bus.W !== 3'b000) begin errors++; $display("FAIL step_pause actual=%b required=000", bus.W); end
    for (int p = 0; p < 2; p++) begin
      bus.QD = 1'b0;
      for (int i = 0; i < 5; i++) step();
      bus.QD = 1'b1;
      beats = 0;
      for (int i = 1; i <= 20; i++) begin
        step();
        if (bus.W !== 3'b000) beats++;
        if (i == 3) begin
          checks++; if (bus.W !== 3'b001) begin errors++; $display("FAIL step_press%0d_b1 actual=%b required=001", p, bus.W); end
        end else if (i == 4) begin
          checks++; if (bus.W !== 3'b010) begin errors++; $display("FAIL step_press%0d_b2 actual=%b required=010", p, bus.W); end
        end
      end
      checks++; if (beats != 2) begin errors++; $display("FAIL step_press%0d_beats actual=%0d required=2", p, beats); end
    end
    bus.STEP_MODE = 1'b0;
  endtask

  task automatic test_counters_async_clr();
    CLR = 1'b1; bus.QD = 1'b0; bus.SHORT = 1'b1; bus.LONG = 1'b0;
    step(); step();
    CLR = 1'b0;
    bus.QD = 1'b1;
    step(); step(); step();
    checks++; if (bus.W !== 3'b001) begin errors++; $display("FAIL cnt_start actual=%b required=001", bus.W); end
    for (int i = 0; i < 17; i++) step();
    checks++; if (bus.INSTR_CNT !== EXP_WRAP) begin
      errors++; $display("FAIL instr_cnt_wrap actual=%0d required=%0d", bus.INSTR_CNT, EXP_WRAP); end
    checks++; if (bus.BEAT_CNT !== EXP_WRAP) begin
      errors++; $display("FAIL beat_cnt_wrap actual=%0d required=%0d", bus.BEAT_CNT, EXP_WRAP); end
    bus.SHORT = 1'b0;
    step();
    checks++; if (bus.W !== 3'b010) begin errors++; $display("FAIL cnt_b2 actual=%b required=010", bus.W); end
    #2;
    CLR = 1'b1;
    #1;
    checks++; if (bus.W !== 3'b000 || bus.RUN !== 1'b0 || bus.INSTR_END !== 1'b0) begin
      errors++; $display("FAIL async_clr actual=%b/%b/%b required=000/0/0", bus.W, bus.RUN, bus.INSTR_END); end
    checks++; if (bus.BEAT_CNT !== 4'd0 || bus.INSTR_CNT !== 4'd0) begin
      errors++; $display("FAIL async_clr_cnt actual=%0d/%0d required=0/0", bus.BEAT_CNT, bus.INSTR_CNT); end
    bus.QD = 1'b0;
    step();
    CLR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.W !== 3'b000) begin errors++; $display("FAIL post_clr_idle cyc=%0d actual=%b required=000", i, bus.W); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    CLR = 1'b1;
    test_reset();
    test_start_short();
    test_two_beat();
    test_three_beat();
    test_stop_resume();
    test_step_mode();
    test_counters_async_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Timing generator for the hardwired controller. Produces the one-hot beat vector W[3:1] that the instruction decoder consumes.
- Consumes the decoder's SHORT, LONG and STOP requests, and the operator start button QD.
- Owns run, halt and single-step sequencing of the whole datapath: the decoder never advances beats itself.

Parameters:
- SYNC_STAGES, 2: number of flops synchronising QD (minimum 2).
- CNT_W, 16: width of the performance counters (Optional Feature only).

Ports:
- T3  input  1  beat clock; all state updates on posedge.
- CLR  input  1  reset; asynchronous, active-high.
- QD  input  1  start/continue push-button, asynchronous level.
- STEP_MODE  input  1  1 = pause after every instruction.
- SHORT  input  1  decoder: instruction ends after W[1].
- LONG  input  1  decoder: instruction needs W[3].
- STOP  input  1  decoder/console: pause after current beat.
- W  output  3 ([3:1])  one-hot beat, 000 when not running.
- RUN  output  1  1 while a beat is active.
- INSTR_END  output  1  combinational; high during the final beat of an instruction.
- BEAT_CNT  output  CNT_W  beats executed (Optional Feature).
- INSTR_CNT  output  CNT_W  instructions completed (Optional Feature).

Behaviour:
- States: IDLE, B1, B2, B3, PAUSE.
- W mapping: B1=001, B2=010, B3=100; IDLE and PAUSE = 000.
- RUN = 1 in B1/B2/B3 only.
- Reset (CLR=1, asynchronous):
  - state=IDLE, W=000, RUN=0, INSTR_END=0.
  - resume register = B1.
  - QD synchroniser flops cleared.
  - counters = 0.
- QD handling:
  - QD passes through SYNC_STAGES flops plus one edge-detect flop.
  - qd_edge = sync_out & ~delayed.
  - A QD rise held across posedges reaches the state machine on the (SYNC_STAGES+1)th posedge; W becomes active after that posedge.
- IDLE: qd_edge -> B1; otherwise stay.
- Beat ends. The beat is the last one of an instruction when any of these holds:
  - in B1 with SHORT=1;
  - in B2 with LONG=0;
  - in B3.
- INSTR_END is 1 exactly in those cases.
- Normal advance:
  - B1 & !SHORT -> B2.
  - B2 & LONG -> B3.
  - Last beat -> B1 of the next instruction.
- LONG is sampled only in B2 and ignored in B1/B3.
- SHORT is sampled only in B1.
- SHORT=1 and LONG=1 together in B1: SHORT wins.
- STOP (highest priority):
  - STOP=1 at the posedge ending any beat -> PAUSE.
  - The resume register captures the beat that would otherwise have followed.
- Step mode: STEP_MODE=1 on a last beat with STOP=0 -> PAUSE, resume=B1.
- PAUSE:
  - W=000.
  - qd_edge -> the state held in the resume register.
  - QD held high does not retrigger; a fresh rise is required.
- qd_edge while in B1/B2/B3 is ignored and is not queued.
- STEP_MODE changes take effect at the next last-beat boundary only.
- Illegal state encoding recovers to IDLE on the next posedge.
- CLR asserted mid-beat: W drops to 000 immediately, without waiting for a clock edge.
- CLR deasserted: stay IDLE until a new qd_edge.

Optional Feature:
- Macro: BEAT_SEQ_PERF_CNT_EN.
- Defined:
  - BEAT_CNT increments at every posedge where RUN=1.
  - INSTR_CNT increments at every posedge where INSTR_END=1.
  - Both counters wrap modulo 2^CNT_W.
  - Both are cleared only by CLR.
- Undefined: BEAT_CNT and INSTR_CNT are driven constant 0, and no counter flops are synthesised.

Test Plan:
- Reset and start: CLR pulse, QD rise, SHORT=1 -> W=000 for 3 posedges, then W sequence 001,001,001..., INSTR_END=1 on every beat.
- Two-beat instruction: SHORT=0, LONG=0 -> W 001,010,001,010; INSTR_END high only in W=010.
- Three-beat instruction: SHORT=0, LONG=1 in B2 -> W 001,010,100,001. Also LONG=1 with SHORT=1 in B1 -> stays 001 (SHORT wins).
- Mid-instruction stop: STOP=1 during W=001 with SHORT=0 -> W=000 (PAUSE) held for 10 cycles; QD re-press -> resumes at 010, not 001.
- Step mode: STEP_MODE=1, SHORT=0, LONG=0 -> W 001,010,000...; each QD press runs exactly one 2-beat instruction. QD held high across 20 cycles -> only one instruction runs.
- Async reset and counters (macro defined, CNT_W=4): 17 SHORT instructions -> INSTR_CNT=1 (wrapped), BEAT_CNT=1. CLR mid-B2 -> W=000 and counters 0 before the next T3 edge.
